parity_checker: RTL and testbench
=================================

// Module: parity_checker
// PURPOSE
//  Receive side of the lane-parity path: accepts DATA_WIDTH data beats with one parity bit per LANE_WIDTH lane.
//  Recomputes even parity per lane (parity bit = XOR of lane bits) and compares it with the received bits.
//  Accumulates lane mismatches over a multi-beat frame, then issues one report per frame.
//  Sits between the link/buffer output and the ALU result consumer.
//  Keeps a saturating count of errored frames for status readback.
// PARAMETERS
//  DATA_WIDTH  256  data beat width; must be a multiple of LANE_WIDTH
//  LANE_WIDTH  8    bits covered by one parity bit; NLANES = DATA_WIDTH/LANE_WIDTH (32)
//  CNT_WIDTH   16   width of beat counter and errored-frame counter
// PORTS
//  clk           in   1           clock, all logic on rising edge
//  rst           in   1           synchronous, active-high reset
//  in_valid      in   1           input beat valid
//  in_ready      out  1           checker can accept a beat
//  in_data       in   DATA_WIDTH  data beat
//  in_par        in   NLANES      received parity bits, bit k covers in_data[k*LANE_WIDTH +: LANE_WIDTH]
//  in_last       in   1           final beat of frame
//  out_valid     out  1           frame report valid
//  out_ready     in   1           consumer takes report
//  out_err       out  1           OR of out_err_mask
//  out_err_mask  out  NLANES      lanes that mismatched on any beat of the frame
//  out_beats     out  CNT_WIDTH   beats in frame, saturating at all-ones
//  err_count     out  CNT_WIDTH   errored frames reported since reset/clear, saturating
//  clr_count     in   1           synchronous clear of err_count
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=0 during rst, 1 in first cycle after; out_valid=0; out_err=0.
//  Reset, continued: out_err_mask=0, out_beats=0, err_count=0; internal mask/beat accumulators=0.
//  Beat accepted when in_valid && in_ready. mism[k] = (^lane_k) ^ in_par[k].
//  FSM IDLE: in_ready=1. On accept, mask_acc<=mism and beat_acc<=1.
//  FSM IDLE exits: in_last=1 -> REPORT; else -> ACCUM.
//  FSM ACCUM: in_ready=1. On accept, mask_acc<=mask_acc|mism and beat_acc<=beat_acc+1 (saturating).
//  FSM ACCUM exits: in_last=1 -> REPORT. No accept: hold.
//  FSM REPORT: in_ready=0 and out_valid=1. Outputs are registered copies of the accumulators, stable until handshake.
//  FSM REPORT exit: on out_valid && out_ready -> IDLE; out_valid=0 next cycle.
//  Latency: out_valid asserts the cycle after the last beat is accepted (1 clk).
//  Throughput: one frame per (beats+1) cycles min; no beat accepted in REPORT.
//  Report handshake with out_err=1 increments err_count; holds at 2^CNT_WIDTH-1.
//  clr_count=1 zeroes err_count next cycle.
//  clr_count coinciding with an errored report: clear wins, increment dropped.
//  in_par/in_data X when in_valid=0 has no effect; in_last ignored unless beat accepted.
//  rst mid-frame or in REPORT: frame discarded, no report, err_count zeroed.
//  out_valid deasserts only after handshake; the report never changes while waiting.
// STRUCTURE
//  Shared package parity_pkg:
//   - PAR_LANE_WIDTH=8 and PAR_DATA_WIDTH=256 constants.
//   - Function lane_parity(data) -> NLANES vector, shared with the parity generator.
//   - State enum {IDLE, ACCUM, REPORT}.
//  One sub-module, parity_lane_calc (combinational per-lane XOR, generate loop over lanes).
//  FSM, accumulators and counters stay in parity_checker.
// TESTING
//  1 Single beat, data=0, par=0, last=1 -> out_valid next clk, err=0, mask=0, beats=1, err_count=0.
//  2 Single beat, data=32'h1 in lane0, par=0 -> mask=32'h1, err=1, err_count=1 after handshake.
//  3 3-beat frame: lane3 bad on beat1, lane7 bad on beat3 -> mask=32'h88, beats=3, err_count=1.
//  4 Report held with out_ready=0 for 5 clk -> in_ready=0, outputs stable. Then ready=1 -> IDLE, next frame accepted.
//  5 clr_count on same cycle as errored report handshake (err_count=4) -> err_count=0 next clk.
//  6 rst asserted mid 4-beat frame after beat2 -> no out_valid; fresh 1-beat clean frame reports beats=1, mask=0.

Source files
------------

// File: rtl/parity_pkg.sv
`default_nettype none
// ============================================================================
// Module   : parity_pkg
// Purpose  : Shared lane-parity constants, FSM state type and the per-lane
//            parity function used by both the generator and the checker.
// Revision : 1.0 - initial release
// ============================================================================
package parity_pkg;

   localparam int PAR_LANE_WIDTH = 8;
   localparam int PAR_DATA_WIDTH = 256;
   localparam int PAR_NLANES     = PAR_DATA_WIDTH / PAR_LANE_WIDTH;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      REPORT = 2'd2
   } state_t;

   // Even parity per lane: bit k is the XOR of lane k.
   function automatic logic [PAR_NLANES-1:0] lane_parity(
      input logic [PAR_DATA_WIDTH-1:0] data
   );
      logic [PAR_NLANES-1:0] p;
      p = '0;
      for (int k = 0; k < PAR_NLANES; k++) begin
         p[k] = ^data[k*PAR_LANE_WIDTH +: PAR_LANE_WIDTH];
      end
      return p;
   endfunction

endpackage
`default_nettype wire

// File: rtl/parity_lane_calc.sv
`default_nettype none
// ============================================================================
// Module   : parity_lane_calc
// Purpose  : Combinational per-lane parity recompute and mismatch flagging.
// Revision : 1.0 - initial release
// ============================================================================
module parity_lane_calc
   import parity_pkg::*;
#(
   parameter  int DATA_WIDTH = PAR_DATA_WIDTH,
   parameter  int LANE_WIDTH = PAR_LANE_WIDTH,
   localparam int NLANES     = DATA_WIDTH / LANE_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic [NLANES-1:0]     i_par,
   output logic [NLANES-1:0]     o_mism
);

   for (genvar k = 0; k < NLANES; k++) begin : g_lane
      assign o_mism[k] = (^i_data[k*LANE_WIDTH +: LANE_WIDTH]) ^ i_par[k];
   end

endmodule
`default_nettype wire

// File: rtl/parity_checker.sv
`default_nettype none
// ============================================================================
// Module   : parity_checker
// Purpose  : Receive-side lane-parity checker; accumulates lane mismatches
//            over a frame, reports once per frame, counts errored frames.
// Revision : 1.0 - initial release
// ============================================================================
module parity_checker
   import parity_pkg::*;
#(
   parameter  int DATA_WIDTH = PAR_DATA_WIDTH,
   parameter  int LANE_WIDTH = PAR_LANE_WIDTH,
   parameter  int CNT_WIDTH  = 16,
   localparam int NLANES     = DATA_WIDTH / LANE_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [NLANES-1:0]     in_par,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_err,
   output logic [NLANES-1:0]     out_err_mask,
   output logic [CNT_WIDTH-1:0]  out_beats,
   output logic [CNT_WIDTH-1:0]  err_count,
   input  logic                  clr_count
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                 state_q,     state_d;
   logic [NLANES-1:0]      mask_acc_q,  mask_acc_d;
   logic [CNT_WIDTH-1:0]   beat_acc_q,  beat_acc_d;
   logic [NLANES-1:0]      rpt_mask_q,  rpt_mask_d;
   logic [CNT_WIDTH-1:0]   rpt_beats_q, rpt_beats_d;
   logic [CNT_WIDTH-1:0]   err_count_q, err_count_d;

   logic [NLANES-1:0]      mism;
   logic                   accept;
   logic                   rpt_done;
   logic [CNT_WIDTH-1:0]   beat_inc;

   parity_lane_calc #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANE_WIDTH (LANE_WIDTH)
   ) u_lane_calc (
      .i_data (in_data),
      .i_par  (in_par),
      .o_mism (mism)
   );

   // rst gates the handshakes so nothing is accepted or reported while held.
   assign in_ready     = !rst && (state_q != REPORT);
   assign out_valid    = !rst && (state_q == REPORT);
   assign out_err      = |rpt_mask_q;
   assign out_err_mask = rpt_mask_q;
   assign out_beats    = rpt_beats_q;
   assign err_count    = err_count_q;

   assign accept   = in_valid && in_ready;
   assign rpt_done = out_valid && out_ready;
   assign beat_inc = (&beat_acc_q) ? beat_acc_q : beat_acc_q + CNT_ONE;

   always_comb begin
      state_d     = state_q;
      mask_acc_d  = mask_acc_q;
      beat_acc_d  = beat_acc_q;
      rpt_mask_d  = rpt_mask_q;
      rpt_beats_d = rpt_beats_q;
      err_count_d = err_count_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               mask_acc_d = mism;
               beat_acc_d = CNT_ONE;
               if (in_last) begin
                  rpt_mask_d  = mism;
                  rpt_beats_d = CNT_ONE;
                  state_d     = REPORT;
               end else begin
                  state_d     = ACCUM;
               end
            end
         end
         ACCUM: begin
            if (accept) begin
               mask_acc_d = mask_acc_q | mism;
               beat_acc_d = beat_inc;
               if (in_last) begin
                  rpt_mask_d  = mask_acc_q | mism;
                  rpt_beats_d = beat_inc;
                  state_d     = REPORT;
               end
            end
         end
         REPORT: begin
            if (rpt_done) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A clear in the same cycle as an errored report drops the increment.
      if (clr_count) begin
         err_count_d = '0;
      end else if (rpt_done && out_err && !(&err_count_q)) begin
         err_count_d = err_count_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mask_acc_q  <= '0;
         beat_acc_q  <= '0;
         rpt_mask_q  <= '0;
         rpt_beats_q <= '0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         mask_acc_q  <= mask_acc_d;
         beat_acc_q  <= beat_acc_d;
         rpt_mask_q  <= rpt_mask_d;
         rpt_beats_q <= rpt_beats_d;
         err_count_q <= err_count_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_parity_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_checker
// Purpose  : Directed scoreboard bench for parity_checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parity_checker;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [255:0] in_data;
   logic [31:0]  in_par;
   logic         in_last;
   logic         out_valid;
   logic         out_ready;
   logic         out_err;
   logic [31:0]  out_err_mask;
   logic [15:0]  out_beats;
   logic [15:0]  err_count;
   logic         clr_count;

   typedef struct {
      logic [31:0] mask;
      logic [15:0] beats;
      logic        err;
   } rpt_t;

   rpt_t        sb[$];
   int          total = 0;
   int          bad   = 0;
   logic [15:0] exp_cnt = '0;

   parity_checker dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_par       (in_par),
      .in_last      (in_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_err      (out_err),
      .out_err_mask (out_err_mask),
      .out_beats    (out_beats),
      .err_count    (err_count),
      .clr_count    (clr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] good_par(input logic [255:0] d);
      logic [31:0] p;
      for (int k = 0; k < 32; k++) begin
         p[k] = d[k*8] ^ d[k*8+1] ^ d[k*8+2] ^ d[k*8+3]
              ^ d[k*8+4] ^ d[k*8+5] ^ d[k*8+6] ^ d[k*8+7];
      end
      return p;
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] d;
      for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic push(input logic [31:0] m, input logic [15:0] b);
      rpt_t r;
      r.mask  = m;
      r.beats = b;
      r.err   = |m;
      sb.push_back(r);
   endtask

   // Called at a negedge; leaves at the negedge after the beat was accepted.
   task automatic send_beat(input logic [255:0] d, input logic [31:0] flip, input logic l);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_par   = good_par(d) ^ flip;
      in_last  = l;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("beat_accept_timeout", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
      in_par   = '0;
      in_last  = 1'b0;
   endtask

   task automatic get_report(input int hold, input logic clr);
      rpt_t        e;
      int          n;
      logic [31:0] m0;
      logic [15:0] b0;
      chk("latency", 64'(out_valid), 64'd1);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 64'(sb.size()), 64'd1);
         return;
      end
      e = sb.pop_front();
      chk("out_err_mask", 64'(out_err_mask), 64'(e.mask));
      chk("out_beats",    64'(out_beats),    64'(e.beats));
      chk("out_err",      64'(out_err),      64'(e.err));
      chk("in_ready_rpt", 64'(in_ready),     64'd0);
      m0 = out_err_mask;
      b0 = out_beats;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", 64'(out_valid),    64'd1);
         chk("hold_ready", 64'(in_ready),     64'd0);
         chk("hold_mask",  64'(out_err_mask), 64'(m0));
         chk("hold_beats", 64'(out_beats),    64'(b0));
      end
      out_ready = 1'b1;
      clr_count = clr;
      @(posedge clk);
      if (clr)                                exp_cnt = '0;
      else if (e.err && exp_cnt != 16'hFFFF)  exp_cnt = exp_cnt + 16'd1;
      @(negedge clk);
      out_ready = 1'b0;
      clr_count = 1'b0;
      chk("valid_drop", 64'(out_valid), 64'd0);
      chk("err_count",  64'(err_count), 64'(exp_cnt));
   endtask

   initial begin
      logic [255:0] d;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_par    = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      clr_count = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready",  64'(in_ready),     64'd0);
      chk("rst_out_valid", 64'(out_valid),    64'd0);
      chk("rst_out_err",   64'(out_err),      64'd0);
      chk("rst_mask",      64'(out_err_mask), 64'd0);
      chk("rst_beats",     64'(out_beats),    64'd0);
      chk("rst_err_count", 64'(err_count),    64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 64'(in_ready), 64'd1);

      // Single clean zero beat.
      push(32'h0, 16'd1);
      send_beat('0, 32'h0, 1'b1);
      get_report(0, 1'b0);

      // Single beat, lane0 carries a 1 with parity 0.
      push(32'h1, 16'd1);
      d = 256'h1;
      send_beat(d, 32'h1, 1'b1);
      get_report(0, 1'b0);

      // Standalone clear.
      clr_count = 1'b1;
      @(negedge clk);
      clr_count = 1'b0;
      exp_cnt   = '0;
      chk("clr_alone", 64'(err_count), 64'd0);

      // Three-beat frame, lane3 bad on beat1, lane7 bad on beat3.
      push(32'h88, 16'd3);
      send_beat(rnd256(), 32'h08, 1'b0);
      send_beat(rnd256(), 32'h00, 1'b0);
      send_beat(rnd256(), 32'h80, 1'b1);
      get_report(0, 1'b0);

      // Five-beat clean frame with idle gaps inside ACCUM.
      push(32'h0, 16'd5);
      send_beat(rnd256(), 32'h0, 1'b0);
      repeat (2) @(negedge clk);
      chk("accum_no_valid", 64'(out_valid), 64'd0);
      send_beat(rnd256(), 32'h0, 1'b0);
      send_beat(rnd256(), 32'h0, 1'b0);
      @(negedge clk);
      send_beat(rnd256(), 32'h0, 1'b0);
      send_beat(rnd256(), 32'h0, 1'b1);
      get_report(0, 1'b0);

      // Report held 5 clocks with the next frame's beat already offered.
      push(32'h8000_0000, 16'd1);
      send_beat(rnd256(), 32'h8000_0000, 1'b1);
      d        = rnd256();
      push(32'h0, 16'd1);
      in_valid = 1'b1;
      in_data  = d;
      in_par   = good_par(d);
      in_last  = 1'b1;
      get_report(5, 1'b0);
      send_beat(d, 32'h0, 1'b1);
      get_report(0, 1'b0);

      // Two more errored frames bring the count to 4.
      push(32'h0001_0100, 16'd2);
      send_beat(rnd256(), 32'h0000_0100, 1'b0);
      send_beat(rnd256(), 32'h0001_0000, 1'b1);
      get_report(1, 1'b0);
      push(32'h4000_0000, 16'd1);
      send_beat(rnd256(), 32'h4000_0000, 1'b1);
      get_report(0, 1'b0);
      chk("err_count_four", 64'(err_count), 64'd4);

      // Clear coinciding with an errored report handshake.
      push(32'h2, 16'd1);
      send_beat(rnd256(), 32'h2, 1'b1);
      get_report(0, 1'b1);
      chk("clr_wins", 64'(err_count), 64'd0);

      // Errored frame after the clear, then reset mid-frame.
      push(32'h10, 16'd1);
      send_beat(rnd256(), 32'h10, 1'b1);
      get_report(0, 1'b0);
      send_beat(rnd256(), 32'h4, 1'b0);
      send_beat(rnd256(), 32'h0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_ready", 64'(in_ready),  64'd0);
      chk("midrst_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      exp_cnt = '0;
      chk("midrst_err_count", 64'(err_count), 64'd0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("postrst_no_valid", 64'(out_valid), 64'd0);
      end
      push(32'h0, 16'd1);
      send_beat(rnd256(), 32'h0, 1'b1);
      get_report(0, 1'b0);

      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
